cdc_fifo_rd_packer: RTL

//  Read-side consumer of the async CDC FIFO wrapper (FWFT mode, 16-bit words).

---
 rtl/cdc_fifo_rd_packer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cdc_fifo_rd_packer.sv
// FWFT FIFO reader packing PACK_RATIO words per beat; beat valid 2 cycles after last pop, holds under m_ready=0.
// Optional CDC_PACK_FLUSH_EN: flush a partial pack after TIMEOUT idle cycles with a partial m_keep.
module cdc_fifo_rd_packer #(
    parameter int DIN_WIDTH  = 16,
    parameter int PACK_RATIO = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                            rd_clk,
    input  logic                            rst,
    input  logic [DIN_WIDTH-1:0]            fifo_dout,
    input  logic                            fifo_empty,
    output logic                            fifo_rd_en,
    output logic [DIN_WIDTH*PACK_RATIO-1:0] m_data,
    output logic [PACK_RATIO-1:0]           m_keep,
    output logic                            m_valid,
    input  logic                            m_ready
);

    localparam int CW = $clog2(PACK_RATIO + 1);
    localparam logic [CW-1:0] FULL = CW'(PACK_RATIO);

    if (PACK_RATIO < 2 || TIMEOUT < 1) begin : g_bad_param
        $error("cdc_fifo_rd_packer: PACK_RATIO must be >= 2 and TIMEOUT >= 1");
    end

    logic [CW-1:0]                          cnt_q, cnt_d;
    logic [PACK_RATIO-1:0][DIN_WIDTH-1:0]   pack_q, pack_d;
    logic [DIN_WIDTH*PACK_RATIO-1:0]        data_q, data_d;
    logic [PACK_RATIO-1:0]                  keep_q, keep_d;
    logic                                   valid_q, valid_d;
    logic                                   out_free, full, pop, flush;

    assign out_free = !valid_q || m_ready;
    assign full     = (cnt_q == FULL);

`ifdef CDC_PACK_FLUSH_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

    logic [IW-1:0] idle_q, idle_d;
    logic          partial;

    assign partial = (cnt_q != '0) && !full;
    assign flush   = partial && (idle_q == IDLE_MAX) && out_free;

    // Saturates at TIMEOUT so a blocked flush fires as soon as the output frees up.
    always_comb begin
        idle_d = idle_q;
        if (pop || !partial || flush) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign flush = 1'b0;
`endif

    assign fifo_rd_en = !rst && !fifo_empty && (!full || out_free) && !flush;
    assign pop        = fifo_rd_en;

    always_comb begin
        cnt_d   = cnt_q;
        pack_d  = pack_q;
        data_d  = data_q;
        keep_d  = keep_q;
        valid_d = valid_q && !m_ready;
        if (full && out_free) begin
            // Hand the full pack over and let a same-cycle pop start the next one in lane 0.
            data_d  = pack_q;
            keep_d  = '1;
            valid_d = 1'b1;
            pack_d  = '0;
            cnt_d   = '0;
            if (pop) begin
                pack_d[0] = fifo_dout;
                cnt_d     = CW'(1);
            end
        end else if (flush) begin
            data_d  = pack_q;
            valid_d = 1'b1;
            pack_d  = '0;
            cnt_d   = '0;
            for (int i = 0; i < PACK_RATIO; i++) begin
                keep_d[i] = (CW'(i) < cnt_q);
            end
        end else if (pop) begin
            for (int i = 0; i < PACK_RATIO; i++) begin
                if (cnt_q == CW'(i)) begin
                    pack_d[i] = fifo_dout;
                end
            end
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            cnt_q   <= '0;
            pack_q  <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pack_q  <= pack_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            valid_q <= valid_d;
        end
    end

    assign m_data  = data_q;
    assign m_keep  = keep_q;
    assign m_valid = valid_q;

endmodule
